x_delay_sched: RTL and testbench
================================

X_DELAY_SCHED -- requirements
Module: x_delay_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; SHALL be 2..16.
REQ-002 Parameter MXDLY, default 4: delay value width in bits.
REQ-003 Parameter MXID, default 2: requester-index width; SHALL equal ceil(log2(NREQ)).
REQ-004 clock  input  1: the single clock for the block; all flops SHALL be rising-edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 enable  input  1: permits new grants when high.
REQ-007 d  input  NREQ: per-requester trigger levels, synchronous to clock.
REQ-008 delay  input  NREQ*MXDLY: per-requester delay; requester i uses bits [i*MXDLY +: MXDLY].
REQ-009 q  output  1: delayed one-clock pulse.
REQ-010 q_id  output  MXID: index of the requester that owns q; valid while q=1, else 0.
REQ-011 busy  output  1: high while a grant is in flight (states COUNT and FIRE).
REQ-012 pending  output  NREQ: latched, unserviced requests.
REQ-013 overflow  output  NREQ: one-clock pulse per requester whose edge was dropped.

Function
REQ-014 Each requester SHALL edge-detect d[i] as d[i] & ~inhibit[i], where inhibit[i] is d[i] registered. A level held high SHALL produce exactly one request; re-trigger requires d[i] low for at least one cycle.
REQ-015 A detected edge at edge E SHALL set pending[i] at E.
REQ-016 An edge on a requester with pending[i] already 1 SHALL leave pending[i]=1 and pulse overflow[i] for one cycle.
REQ-017 FSM states SHALL be IDLE, COUNT and FIRE.
REQ-018 In IDLE, with enable=1 and pending!=0, the FSM SHALL grant the first set pending bit searching upward from rr_ptr with wrap-around.
REQ-019 On a grant, the FSM SHALL latch the grant index, load cnt with that requester's delay, clear that requester's pending bit, and go to COUNT.
REQ-020 In COUNT: if cnt==0, go to FIRE; otherwise decrement cnt.
REQ-021 In FIRE, q=1 and q_id=grant for exactly one cycle. The FSM SHALL then set rr_ptr=(grant+1) mod NREQ and go to IDLE.
REQ-022 Latency: for a d[i] edge at E0 that is granted immediately at E0+1, q SHALL be high during the cycle following edge E0+delay+2.
REQ-023 delay is sampled only at the grant; later changes SHALL NOT affect the grant in flight.
REQ-024 A new edge on the granted requester in the same cycle as its grant SHALL win: pending stays set and no overflow is raised.
REQ-025 enable=0 SHALL block new grants only. An in-flight COUNT/FIRE SHALL complete, and edges SHALL still latch into pending.
REQ-026 Minimum spacing between consecutive q pulses SHALL be 2 cycles (FIRE→IDLE→grant); no back-to-back pulses.
REQ-027 q, q_id, busy and overflow SHALL be registered or decoded from registered state only, with no combinational path from d.

Reset
REQ-028 While reset_n=0, the block SHALL clear state to IDLE and clear cnt, rr_ptr, grant, inhibit, pending, q, q_id, busy and overflow, independent of clock.
REQ-029 Reset asserted mid-COUNT SHALL discard the grant; no q pulse SHALL follow deassertion.
REQ-030 After reset_n deasserts, a d[i] already high SHALL register as an edge, because inhibit is 0.

Structure
REQ-031 Shared package x_delay_pkg SHALL hold the FSM state encoding (IDLE=0, COUNT=1, FIRE=2) and the default NREQ/MXDLY constants.
REQ-032 Per-requester edge detect plus pending/overflow logic SHALL be one sub-module, x_req_latch, instantiated NREQ times.
REQ-033 The round-robin search SHALL be a combinational function within x_delay_sched, not a separate module.

Verification
REQ-034 Single request: d[1] rises before E0 with delay[1]=3 → q=1, q_id=1 in the cycle after E0+5; busy high from E1 to E5.
REQ-035 Zero delay: delay[0]=0, d[0] edge at E0 → q high in the cycle after E0+2.
REQ-036 Round-robin: d[0..3] rise together at E0, all delays 0 → q_id sequence 0,1,2,3, pulses 3 cycles apart, pending finally 0.
REQ-037 Overflow: d[2] pulses twice while enable=0 → pending[2]=1, overflow[2] pulses once; after enable=1, exactly one q with q_id=2.
REQ-038 Reset mid-COUNT: delay=15, reset_n low at E4 for 1 cycle → q never asserted, all outputs 0; d held high → new request at first edge after release.
REQ-039 Level hold: d[3] held high 40 cycles, delay=2 → exactly one q pulse.

Source files
------------

// File: rtl/x_delay_pkg.sv
// Shared definitions for the delayed-pulse scheduler: FSM encoding and default sizes.
package x_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_MXDLY = 4;

endpackage

// File: rtl/x_req_latch.sv
// One requester slot: rising-edge detect on a level trigger, a pending latch
// cleared by the scheduler's grant, and an overflow pulse for dropped edges.
module x_req_latch (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  input  logic clear,
  output logic pending,
  output logic overflow
);

  logic inhibit;
  logic edge_det;

  assign edge_det = d & ~inhibit;

  // A fresh edge beats a same-cycle clear, so a retrigger during its own grant is kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inhibit  <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      inhibit  <= d;
      overflow <= edge_det & pending & ~clear;
      if (edge_det) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/x_delay_sched.sv
// Round-robin scheduler: grants one pending requester at a time, counts down its
// delay and emits a single-cycle pulse tagged with the requester index.
module x_delay_sched
  import x_delay_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int MXDLY = DEF_MXDLY,
  parameter int MXID  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NREQ-1:0]       d,
  input  logic [NREQ*MXDLY-1:0] delay,
  output logic                  q,
  output logic [MXID-1:0]       q_id,
  output logic                  busy,
  output logic [NREQ-1:0]       pending,
  output logic [NREQ-1:0]       overflow
);

  state_t            state;
  state_t            state_nxt;
  logic [MXDLY-1:0]  cnt;
  logic [MXDLY-1:0]  cnt_nxt;
  logic [MXID-1:0]   grant;
  logic [MXID-1:0]   grant_nxt;
  logic [MXID-1:0]   rr_ptr;
  logic [MXID-1:0]   rr_ptr_nxt;
  logic [NREQ-1:0]   clear;
  logic              found;
  logic [MXID-1:0]   sel;
  logic [MXDLY-1:0]  delay_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign delay_arr[i] = delay[i*MXDLY +: MXDLY];

    x_req_latch u_latch (
      .clock    (clock),
      .reset_n  (reset_n),
      .d        (d[i]),
      .clear    (clear[i]),
      .pending  (pending[i]),
      .overflow (overflow[i])
    );
  end

  // Walk downward so the candidate closest to ptr (k = 0) is the one left standing.
  function automatic logic [MXID:0] rr_pick(input logic [NREQ-1:0] pend,
                                            input logic [MXID-1:0] ptr);
    logic [MXID:0] res;
    logic [MXID:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (MXID+1)'(k);
      if (idx >= (MXID+1)'(NREQ)) begin
        idx = idx - (MXID+1)'(NREQ);
      end
      if (pend[idx[MXID-1:0]]) begin
        res = {1'b1, idx[MXID-1:0]};
      end
    end
    return res;
  endfunction

  assign {found, sel} = rr_pick(pending, rr_ptr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    clear      = '0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          grant_nxt  = sel;
          cnt_nxt    = delay_arr[sel];
          clear[sel] = 1'b1;
          state_nxt  = COUNT;
        end
      end
      COUNT: begin
        if (cnt == '0) begin
          state_nxt = FIRE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      FIRE: begin
        rr_ptr_nxt = (grant == MXID'(NREQ - 1)) ? '0 : grant + 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign q    = (state == FIRE);
  assign q_id = q ? grant : '0;
  assign busy = (state == COUNT) || (state == FIRE);

endmodule

// File: tb/tb_x_delay_sched.sv
// Scoreboard bench for x_delay_sched: each scenario queues the pulses it expects
// and a negedge monitor matches every q pulse against the queue head.
module tb_x_delay_sched;

  localparam int NREQ  = 4;
  localparam int MXDLY = 4;
  localparam int MXID  = 2;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic [NREQ-1:0]       d;
  logic [NREQ*MXDLY-1:0] delay;
  logic                  q;
  logic [MXID-1:0]       q_id;
  logic                  busy;
  logic [NREQ-1:0]       pending;
  logic [NREQ-1:0]       overflow;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   q_pulses = 0;
  int   ovf_cnt [NREQ];

  x_delay_sched #(
    .NREQ  (NREQ),
    .MXDLY (MXDLY),
    .MXID  (MXID)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .d        (d),
    .delay    (delay),
    .q        (q),
    .q_id     (q_id),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Every q pulse must match the oldest expectation in both index and cycle.
  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      if (overflow[i]) ovf_cnt[i]++;
    end
    checks++;
    if (q === 1'b1) begin
      q_pulses++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_q: q_id=%0d at cycle %0d, no pulse expected", q_id, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(q_id) !== e.id || cyc !== e.cyc) begin
          errors++;
          $display("[TB] FAIL q_pulse: got id=%0d cycle=%0d, expected id=%0d cycle=%0d",
                   q_id, cyc, e.id, e.cyc);
        end
      end
    end else if (q !== 1'b0 || q_id !== '0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: q=%b q_id=%0d at cycle %0d, expected q=0 q_id=0",
               q, q_id, cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_delay(input int i, input int v);
    delay[i*MXDLY +: MXDLY] = v[MXDLY-1:0];
  endtask

  task automatic clear_ovf();
    for (int i = 0; i < NREQ; i++) ovf_cnt[i] = 0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected pulses still outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    d       = '0;
    delay   = '0;
    clear_ovf();
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({q, q_id, busy, pending, overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: q=%b q_id=%0d busy=%b pending=%b overflow=%b, expected all 0",
               q, q_id, busy, pending, overflow);
    end
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || pending !== '0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: busy=%b pending=%b, expected 0 and 0", busy, pending);
    end
  endtask

  task automatic test_round_robin();
    int c;
    for (int i = 0; i < NREQ; i++) set_delay(i, 0);
    @(negedge clock);
    d = '1;
    c = cyc;
    for (int i = 0; i < NREQ; i++) sb.push_back('{i, c + 3 + 3 * i});
    repeat (2) @(negedge clock);
    d = '0;
    wait_drain(40);
    checks++;
    if (pending !== '0) begin
      errors++;
      $display("[TB] FAIL rr_pending: pending=%b, expected 0", pending);
    end
  endtask

  task automatic test_single();
    int c;
    set_delay(1, 3);
    @(negedge clock);
    d[1] = 1'b1;
    c = cyc;
    sb.push_back('{1, c + 6});
    @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_busy_pre: busy=%b, expected 0", busy);
    end
    @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_busy_grant: busy=%b, expected 1", busy);
    end
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_busy_fire: busy=%b, expected 1", busy);
    end
    @(negedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_busy_done: busy=%b, expected 0", busy);
    end
    d[1] = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_zero_delay();
    int c;
    set_delay(0, 0);
    @(negedge clock);
    d[0] = 1'b1;
    c = cyc;
    sb.push_back('{0, c + 3});
    repeat (2) @(negedge clock);
    d[0] = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_overflow();
    int e;
    enable = 1'b0;
    set_delay(2, 1);
    clear_ovf();
    for (int p = 0; p < 2; p++) begin
      @(negedge clock);
      d[2] = 1'b1;
      @(negedge clock);
      d[2] = 1'b0;
    end
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (pending !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL ovf_pending: pending=%b, expected 0100", pending);
    end
    checks++;
    if (ovf_cnt[2] !== 1 || ovf_cnt[0] + ovf_cnt[1] + ovf_cnt[3] !== 0) begin
      errors++;
      $display("[TB] FAIL ovf_count: req2=%0d others=%0d, expected 1 and 0",
               ovf_cnt[2], ovf_cnt[0] + ovf_cnt[1] + ovf_cnt[3]);
    end
    @(negedge clock);
    enable = 1'b1;
    e = cyc;
    sb.push_back('{2, e + 3});
    wait_drain(20);
    checks++;
    if (pending !== '0) begin
      errors++;
      $display("[TB] FAIL ovf_pending_after: pending=%b, expected 0", pending);
    end
  endtask

  task automatic test_same_cycle_win();
    int e;
    enable = 1'b0;
    set_delay(0, 0);
    @(negedge clock);
    d[0] = 1'b1;
    @(negedge clock);
    d[0] = 1'b0;
    @(negedge clock);
    clear_ovf();
    @(negedge clock);
    enable = 1'b1;
    d[0]   = 1'b1;
    e = cyc;
    sb.push_back('{0, e + 2});
    sb.push_back('{0, e + 5});
    @(negedge clock);
    #1;
    checks++;
    if (pending[0] !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL win_pending: pending[0]=%b busy=%b, expected 1 and 1", pending[0], busy);
    end
    d[0] = 1'b0;
    wait_drain(20);
    checks++;
    if (ovf_cnt[0] !== 0) begin
      errors++;
      $display("[TB] FAIL win_overflow: overflow pulses=%0d, expected 0", ovf_cnt[0]);
    end
  endtask

  task automatic test_delay_change();
    int c;
    set_delay(1, 5);
    @(negedge clock);
    d[1] = 1'b1;
    c = cyc;
    sb.push_back('{1, c + 8});
    repeat (3) @(negedge clock);
    set_delay(1, 0);
    d[1] = 1'b0;
    wait_drain(30);
  endtask

  task automatic test_reset_mid_count();
    int c;
    int r;
    set_delay(0, 15);
    @(negedge clock);
    d[0] = 1'b1;
    c = cyc;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({q, q_id, busy, pending, overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: q=%b q_id=%0d busy=%b pending=%b overflow=%b, expected all 0",
               q, q_id, busy, pending, overflow);
    end
    @(negedge clock);
    reset_n = 1'b1;
    r = cyc;
    sb.push_back('{0, r + 18});
    @(negedge clock);
    #1;
    checks++;
    if (pending[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_rearm: pending[0]=%b, expected 1 (c=%0d)", pending[0], c);
    end
    wait_drain(40);
    d[0] = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_level_hold();
    int c;
    set_delay(3, 2);
    @(negedge clock);
    q_pulses = 0;
    d[3] = 1'b1;
    c = cyc;
    sb.push_back('{3, c + 5});
    repeat (40) @(negedge clock);
    d[3] = 1'b0;
    wait_drain(10);
    checks++;
    if (q_pulses !== 1) begin
      errors++;
      $display("[TB] FAIL level_hold: q pulses=%0d, expected 1", q_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_delay();
    test_overflow();
    test_same_cycle_win();
    test_delay_change();
    test_reset_mid_count();
    test_level_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
